// File: rtl/fetch_buffered.sv
// Buffered instruction-fetch front end: issues PC-sequential requests to an in-order
// variable-latency instruction memory and queues returned instructions toward decode.
module fetch_buffered #(
   parameter int unsigned     XLEN            = 64,
   parameter int unsigned     ILEN            = 32,
   parameter int unsigned     DEPTH           = 4,
   parameter int unsigned     MAX_OUTSTANDING = 2,
   parameter logic [XLEN-1:0] RESET_PC        = '0
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       redirect_i,
   input  logic [XLEN-1:0]            redirect_pc_i,
   output logic                       imem_req_valid_o,
   input  logic                       imem_req_ready_i,
   output logic [XLEN-1:0]            imem_req_addr_o,
   input  logic                       imem_rsp_valid_i,
   input  logic [ILEN-1:0]            imem_rsp_instr_i,
   output logic                       dec_valid_o,
   input  logic                       dec_ready_i,
   output logic [ILEN-1:0]            dec_instr_o,
   output logic [XLEN-1:0]            dec_pc_o,
   output logic [XLEN-1:0]            dec_pc_plus4_o,
   output logic [$clog2(DEPTH):0]     occupancy_o
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
   localparam int unsigned SW = ((CW > OW) ? CW : OW) + 1;

   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
   logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
   logic [OW-1:0]   outst_q, outst_d;
   logic [OW-1:0]   discard_q, discard_d;
   logic [CW-1:0]   count_q, count_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;

   logic [ILEN-1:0] instr_mem_q [DEPTH];
   logic [XLEN-1:0] pc_mem_q    [DEPTH];

   logic [SW-1:0]   credit_used;
   logic            req_valid;
   logic            req_fire;
   logic            head_valid;
   logic            pop;
   logic            push;
   logic            discard_nz;

   // Entries promised to the queue: buffered ones plus responses still due that will be kept.
   assign credit_used = SW'(count_q) + SW'(outst_q) - SW'(discard_q);

   assign req_valid  = rst_n & ~redirect_i
                     & (outst_q < OW'(MAX_OUTSTANDING))
                     & (credit_used < SW'(DEPTH));
   assign req_fire   = req_valid & imem_req_ready_i;
   assign head_valid = (count_q != '0);
   assign discard_nz = (discard_q != '0);
   assign pop        = head_valid & ~redirect_i & dec_ready_i;
   assign push       = imem_rsp_valid_i & ~redirect_i & ~discard_nz;

   assign imem_req_valid_o = req_valid;
   assign imem_req_addr_o  = fetch_pc_q;
   assign dec_valid_o      = head_valid & ~redirect_i;
   assign occupancy_o      = count_q;

   // The head is masked when empty so decode sees zeros after reset without clearing storage.
   assign dec_instr_o    = head_valid ? instr_mem_q[rd_ptr_q] : '0;
   assign dec_pc_o       = head_valid ? pc_mem_q[rd_ptr_q] : '0;
   assign dec_pc_plus4_o = head_valid ? (pc_mem_q[rd_ptr_q] + XLEN'(4)) : '0;

   always_comb begin
      // NOTE: every next-state signal gets its hold value first so no path infers a latch.
      fetch_pc_d = fetch_pc_q;
      rsp_pc_d   = rsp_pc_q;
      outst_d    = outst_q;
      discard_d  = discard_q;
      count_d    = count_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;

      if (redirect_i) begin
         fetch_pc_d = redirect_pc_i;
         rsp_pc_d   = redirect_pc_i;
         outst_d    = outst_q - OW'(imem_rsp_valid_i);
         discard_d  = outst_q - OW'(imem_rsp_valid_i);
         count_d    = '0;
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
      end else begin
         if (req_fire) begin
            fetch_pc_d = fetch_pc_q + XLEN'(4);
         end
         outst_d = outst_q + OW'(req_fire) - OW'(imem_rsp_valid_i);
         if (imem_rsp_valid_i && discard_nz) begin
            discard_d = discard_q - OW'(1);
         end
         if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
            rsp_pc_d = rsp_pc_q + XLEN'(4);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end
         count_d = count_q + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
      if (!rst_n) begin
         fetch_pc_q <= RESET_PC;
         rsp_pc_q   <= RESET_PC;
         outst_q    <= '0;
         discard_q  <= '0;
         count_q    <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         rsp_pc_q   <= rsp_pc_d;
         outst_q    <= outst_d;
         discard_q  <= discard_d;
         count_q    <= count_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
      end
   end

   // NOTE: queue storage has no reset; count_q alone decides which slots are meaningful.
   always_ff @(posedge clk) begin
      if (push) begin
         instr_mem_q[wr_ptr_q] <= imem_rsp_instr_i;
         pc_mem_q[wr_ptr_q]    <= rsp_pc_q;
      end
   end

endmodule

// File: tb/tb_fetch_buffered.sv
// Randomized bench for fetch_buffered: an in-order memory model plus a transaction-level
// model of which fetched PCs must reach decode, in what order, and when fetch may request.
module tb_fetch_buffered;

   localparam int          XLEN     = 64;
   localparam int          ILEN     = 32;
   localparam int          DEPTH    = 4;
   localparam int          MAXO     = 2;
   localparam logic [63:0] RESET_PC = 64'h0;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             redirect_i;
   logic [XLEN-1:0]  redirect_pc_i;
   logic             imem_req_valid_o;
   logic             imem_req_ready_i;
   logic [XLEN-1:0]  imem_req_addr_o;
   logic             imem_rsp_valid_i;
   logic [ILEN-1:0]  imem_rsp_instr_i;
   logic             dec_valid_o;
   logic             dec_ready_i;
   logic [ILEN-1:0]  dec_instr_o;
   logic [XLEN-1:0]  dec_pc_o;
   logic [XLEN-1:0]  dec_pc_plus4_o;
   logic [$clog2(DEPTH):0] occupancy_o;

   fetch_buffered #(
      .XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .RESET_PC(RESET_PC)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
      .imem_req_valid_o(imem_req_valid_o), .imem_req_ready_i(imem_req_ready_i),
      .imem_req_addr_o(imem_req_addr_o),
      .imem_rsp_valid_i(imem_rsp_valid_i), .imem_rsp_instr_i(imem_rsp_instr_i),
      .dec_valid_o(dec_valid_o), .dec_ready_i(dec_ready_i),
      .dec_instr_o(dec_instr_o), .dec_pc_o(dec_pc_o), .dec_pc_plus4_o(dec_pc_plus4_o),
      .occupancy_o(occupancy_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] addr;
      int          due;
      bit          stale;
   } pend_t;

   pend_t       pend[$];      // requests accepted by memory, oldest first
   logic [63:0] mq[$];        // PCs that decode is still owed, oldest first
   logic [63:0] fetch_addr;
   int          cyc;
   int          n_checks;
   int          n_pass;
   bit          just_reset;
   int          pops;

   int          lat_min, lat_max, req_rdy_pct, dec_rdy_pct, redir_pct, redir_mode;
   logic [63:0] redir_target;
   bit          redir_done;

   function automatic logic [31:0] instr_of(input logic [63:0] a);
      return a[31:0] ^ a[63:32] ^ 32'h1357_9BDF;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, obs, exp, cyc);
   endtask

   task automatic step(input bit rst_val);
      bit          rsp_now;
      bit          do_redir;
      bit          exp_rv;
      bit          exp_dv;
      int          nonstale;
      int          lat;
      pend_t       p;
      logic [63:0] rpc;

      @(negedge clk);
      rst_n   = rst_val;
      rsp_now = rst_val && (pend.size() > 0) && (pend[0].due <= cyc);
      imem_rsp_valid_i = rsp_now;
      imem_rsp_instr_i = '0;
      if (rsp_now) imem_rsp_instr_i = instr_of(pend[0].addr);
      imem_req_ready_i = ($urandom_range(99) < req_rdy_pct);
      dec_ready_i      = ($urandom_range(99) < dec_rdy_pct);

      rpc = {$urandom(), $urandom()} & 64'hFFFF_FFFF_FFFF_FFFC;
      if ($urandom_range(7) == 0) rpc = 64'hFFFF_FFFF_FFFF_FFF8;
      do_redir = 1'b0;
      if (rst_val) begin
         case (redir_mode)
            1: do_redir = ($urandom_range(99) < redir_pct);
            2: if (pend.size() == 2 && !rsp_now) begin
                  do_redir = 1'b1; rpc = redir_target; redir_mode = 0; redir_done = 1'b1;
               end
            3: if (pend.size() == 2 && rsp_now && mq.size() > 0 && dec_ready_i) begin
                  do_redir = 1'b1; rpc = redir_target; redir_mode = 0; redir_done = 1'b1;
               end
            default: do_redir = 1'b0;
         endcase
      end
      redirect_i    = do_redir;
      redirect_pc_i = rpc;
      #1;

      if (!rst_val) begin
         check("req_valid_in_reset", imem_req_valid_o, 0);
      end else begin
         nonstale = 0;
         foreach (pend[i]) if (!pend[i].stale) nonstale++;
         exp_rv = !do_redir && (pend.size() < MAXO) && (mq.size() + nonstale < DEPTH);
         exp_dv = (mq.size() != 0) && !do_redir;
         check("req_valid", imem_req_valid_o, exp_rv);
         check("req_addr", imem_req_addr_o, fetch_addr);
         check("dec_valid", dec_valid_o, exp_dv);
         check("occupancy", occupancy_o, mq.size());
         if (exp_dv) begin
            check("dec_pc", dec_pc_o, mq[0]);
            check("dec_pc_plus4", dec_pc_plus4_o, mq[0] + 64'd4);
            check("dec_instr", dec_instr_o, instr_of(mq[0]));
         end
         if (just_reset) begin
            check("post_reset_dec_instr", dec_instr_o, 0);
            check("post_reset_dec_pc", dec_pc_o, 0);
            check("post_reset_dec_pc_plus4", dec_pc_plus4_o, 0);
         end

         if (do_redir) begin
            if (rsp_now) void'(pend.pop_front());
            foreach (pend[i]) pend[i].stale = 1'b1;
            mq.delete();
            fetch_addr = rpc;
         end else begin
            if (exp_dv && dec_ready_i) begin
               void'(mq.pop_front());
               pops++;
            end
            if (rsp_now) begin
               p = pend.pop_front();
               if (!p.stale) mq.push_back(p.addr);
            end
            if (exp_rv && imem_req_ready_i) begin
               lat = int'($urandom_range(lat_max, lat_min));
               pend.push_back('{addr: fetch_addr, due: cyc + lat, stale: 1'b0});
               fetch_addr = fetch_addr + 64'd4;
            end
         end
      end

      if (!rst_val) begin
         pend.delete();
         mq.delete();
         fetch_addr = RESET_PC;
      end
      just_reset = !rst_val;
      cyc++;
   endtask

   task automatic wait_first_pc(input string tag, input logic [63:0] want);
      bit found;
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         step(1'b1);
         if (dec_valid_o) begin
            check(tag, dec_pc_o, want);
            found = 1'b1;
         end
      end
      check({tag, "_delivered"}, found, 1);
   endtask

   initial begin
      n_checks = 0; n_pass = 0; cyc = 0; pops = 0; just_reset = 1'b0;
      fetch_addr = RESET_PC;
      rst_n = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
      imem_req_ready_i = 1'b0; imem_rsp_valid_i = 1'b0; imem_rsp_instr_i = '0;
      dec_ready_i = 1'b0;
      lat_min = 1; lat_max = 1; req_rdy_pct = 100; dec_rdy_pct = 100;
      redir_pct = 0; redir_mode = 0; redir_target = '0; redir_done = 1'b0;

      repeat (2) step(1'b0);

      // Sequential fetch at one instruction per cycle.
      repeat (3) step(1'b1);
      pops = 0;
      repeat (20) step(1'b1);
      check("throughput_pops", pops, 20);

      // Decode stalls: queue fills, requests stop, then drains in order.
      dec_rdy_pct = 0;
      repeat (15) step(1'b1);
      check("full_occupancy", occupancy_o, DEPTH);
      check("full_no_req", imem_req_valid_o, 0);
      dec_rdy_pct = 100;
      repeat (10) step(1'b1);

      // Redirect while two responses are outstanding.
      lat_min = 3; lat_max = 3;
      redir_target = 64'h100; redir_done = 1'b0; redir_mode = 2;
      for (int i = 0; i < 40 && !redir_done; i++) step(1'b1);
      check("redirect_outstanding_taken", redir_done, 1);
      step(1'b1);
      check("occupancy_after_redirect", occupancy_o, 0);
      wait_first_pc("first_pc_after_redirect", 64'h100);

      // Redirect colliding with a response and a decode pop.
      lat_min = 1; lat_max = 3; dec_rdy_pct = 50;
      redir_target = 64'h200; redir_done = 1'b0; redir_mode = 3;
      for (int i = 0; i < 400 && !redir_done; i++) step(1'b1);
      check("redirect_collision_taken", redir_done, 1);
      dec_rdy_pct = 100;
      wait_first_pc("first_pc_after_collision", 64'h200);

      // Random backpressure, latency and redirects.
      req_rdy_pct = 60; dec_rdy_pct = 70; redir_pct = 3; redir_mode = 1;
      repeat (3000) step(1'b1);

      // Reset with a full queue.
      redir_mode = 0; lat_min = 1; lat_max = 1; req_rdy_pct = 100; dec_rdy_pct = 0;
      for (int i = 0; i < 40 && occupancy_o != DEPTH; i++) step(1'b1);
      check("fill_before_reset", occupancy_o, DEPTH);
      step(1'b0);
      step(1'b1);
      dec_rdy_pct = 100;
      repeat (20) step(1'b1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
